// File: rtl/tx_char_scheduler.sv
// SpaceWire TX character scheduler: picks time-code, FCT, N-Char or NULL for the
// encoder each time it is free, and tracks owed FCTs and the pending time-code.
module tx_char_scheduler #(
  parameter int unsigned OWED_W = 3
) (
  input  logic              pclk_tx,
  input  logic              rst_tx,
  input  logic              send_null_tx,
  input  logic              send_fct_tx,
  input  logic              send_nchar_tx,
  input  logic              tickin_tx,
  input  logic [7:0]        timein_tx,
  input  logic              fct_grant_tx,
  input  logic [5:0]        fct_credit_tx,
  input  logic              fifo_empty_tx,
  input  logic [8:0]        fifo_data_tx,
  input  logic              enc_ready_tx,
  output logic              enc_valid_tx,
  output logic [1:0]        enc_type_tx,
  output logic [8:0]        enc_data_tx,
  output logic              fifo_rd_tx,
  output logic              char_sent,
  output logic [OWED_W-1:0] fct_owed_tx,
  output logic              tick_pending_tx
);

  typedef enum logic {IDLE, HOLD} state_t;
  typedef enum logic [1:0] {
    CH_NULL  = 2'b00,
    CH_FCT   = 2'b01,
    CH_NCHAR = 2'b10,
    CH_TIME  = 2'b11
  } char_t;

  localparam logic [OWED_W-1:0] OWED_MAX = '1;

  state_t     state;
  char_t      enc_type_q;
  logic [7:0] time_q;
  logic       xfer;
  logic       fct_xfer;
  logic       time_xfer;

  assign enc_type_tx = enc_type_q;

  always_comb begin
    xfer      = (state == HOLD) && enc_ready_tx;
    fct_xfer  = xfer && (enc_type_q == CH_FCT);
    time_xfer = xfer && (enc_type_q == CH_TIME);
  end

  always_ff @(posedge pclk_tx) begin
    // Link down shares the reset path; only a real reset also clears the time value.
    if (rst_tx || !send_null_tx) begin
      state           <= IDLE;
      enc_valid_tx    <= 1'b0;
      enc_type_q      <= CH_NULL;
      enc_data_tx     <= '0;
      fifo_rd_tx      <= 1'b0;
      char_sent       <= 1'b0;
      fct_owed_tx     <= '0;
      tick_pending_tx <= 1'b0;
      if (rst_tx) time_q <= '0;
    end else begin
      fifo_rd_tx <= 1'b0;
      char_sent  <= 1'b0;

      // Grant and FCT transfer together cancel; a grant at saturation is dropped.
      if (fct_grant_tx && !fct_xfer && (fct_owed_tx != OWED_MAX))
        fct_owed_tx <= fct_owed_tx + OWED_W'(1);
      else if (fct_xfer && !fct_grant_tx)
        fct_owed_tx <= fct_owed_tx - OWED_W'(1);

      if (tickin_tx && send_nchar_tx) begin
        tick_pending_tx <= 1'b1;
        time_q          <= timein_tx;
      end else if (time_xfer) begin
        tick_pending_tx <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          enc_valid_tx <= 1'b1;
          state        <= HOLD;
          if (tick_pending_tx && send_nchar_tx) begin
            enc_type_q  <= CH_TIME;
            enc_data_tx <= {1'b0, time_q};
          end else if ((fct_owed_tx != '0) && send_fct_tx) begin
            enc_type_q  <= CH_FCT;
            enc_data_tx <= '0;
          end else if (!fifo_empty_tx && send_nchar_tx && (fct_credit_tx != '0)) begin
            enc_type_q  <= CH_NCHAR;
            enc_data_tx <= fifo_data_tx;
            fifo_rd_tx  <= 1'b1;
          end else begin
            enc_type_q  <= CH_NULL;
            enc_data_tx <= '0;
          end
        end
        HOLD: begin
          if (enc_ready_tx) begin
            enc_valid_tx <= 1'b0;
            state        <= IDLE;
            char_sent    <= (enc_type_q == CH_NCHAR);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_char_scheduler.sv
// Scoreboard bench for tx_char_scheduler: FIFO and credit counter are modelled here,
// non-NULL transfers are matched against a queue of expected characters.
module tb_tx_char_scheduler;

  logic       pclk_tx = 1'b0;
  logic       rst_tx;
  logic       send_null_tx, send_fct_tx, send_nchar_tx;
  logic       tickin_tx;
  logic [7:0] timein_tx;
  logic       fct_grant_tx;
  logic [5:0] fct_credit_tx;
  logic       fifo_empty_tx;
  logic [8:0] fifo_data_tx;
  logic       enc_ready_tx;
  logic       enc_valid_tx;
  logic [1:0] enc_type_tx;
  logic [8:0] enc_data_tx;
  logic       fifo_rd_tx;
  logic       char_sent;
  logic [2:0] fct_owed_tx;
  logic       tick_pending_tx;

  tx_char_scheduler #(.OWED_W(3)) dut (
    .pclk_tx(pclk_tx), .rst_tx(rst_tx),
    .send_null_tx(send_null_tx), .send_fct_tx(send_fct_tx), .send_nchar_tx(send_nchar_tx),
    .tickin_tx(tickin_tx), .timein_tx(timein_tx), .fct_grant_tx(fct_grant_tx),
    .fct_credit_tx(fct_credit_tx), .fifo_empty_tx(fifo_empty_tx), .fifo_data_tx(fifo_data_tx),
    .enc_ready_tx(enc_ready_tx), .enc_valid_tx(enc_valid_tx), .enc_type_tx(enc_type_tx),
    .enc_data_tx(enc_data_tx), .fifo_rd_tx(fifo_rd_tx), .char_sent(char_sent),
    .fct_owed_tx(fct_owed_tx), .tick_pending_tx(tick_pending_tx)
  );

  always #5 pclk_tx = ~pclk_tx;

  typedef struct {
    logic [1:0] typ;
    logic [8:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] fq[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_nulls  = 0;
  int         n_sent   = 0;
  int         n_pops   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic fifo_sync();
    fifo_empty_tx = (fq.size() == 0);
    fifo_data_tx  = (fq.size() == 0) ? 9'h000 : fq[0];
  endtask

  task automatic expect_char(input logic [1:0] typ, input logic [8:0] data);
    exp_t e;
    e.typ  = typ;
    e.data = data;
    sb.push_back(e);
  endtask

  // Inputs are settled at entry, so a valid&ready seen now transfers at the next edge.
  task automatic step();
    exp_t e;
    if (enc_valid_tx === 1'b1 && enc_ready_tx && send_null_tx && !rst_tx) begin
      if (enc_type_tx == 2'b00) n_nulls++;
      else if (sb.size() == 0) check("sb_unexpected", {enc_type_tx, enc_data_tx}, 32'h0);
      else begin
        e = sb.pop_front();
        check("sb_type", enc_type_tx, e.typ);
        if (e.typ[1]) check("sb_data", enc_data_tx, e.data);
      end
    end
    @(negedge pclk_tx);
    if (char_sent === 1'b1) begin
      n_sent++;
      if (fct_credit_tx != 0) fct_credit_tx = fct_credit_tx - 6'd1;
    end
    if (fifo_rd_tx === 1'b1 && fq.size() != 0) begin
      void'(fq.pop_front());
      n_pops++;
    end
    fifo_sync();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 10 && enc_valid_tx; k++) step();
    check("idle_reached", enc_valid_tx, 0);
  endtask

  int pops0, sent0, nulls0;

  initial begin
    rst_tx = 1'b1; send_null_tx = 1'b1; send_fct_tx = 1'b0; send_nchar_tx = 1'b0;
    tickin_tx = 1'b0; timein_tx = 8'h00; fct_grant_tx = 1'b0; fct_credit_tx = 6'd0;
    enc_ready_tx = 1'b1;
    fifo_sync();
    steps(3);
    check("reset_outs", {enc_valid_tx, enc_type_tx, enc_data_tx, fifo_rd_tx, char_sent,
                         fct_owed_tx, tick_pending_tx}, 0);

    // NULLs alternate with idle cycles; a tick outside Run is ignored
    rst_tx = 1'b0;
    tickin_tx = 1'b1; timein_tx = 8'h77;
    step();
    tickin_tx = 1'b0;
    check("null_valid0", {enc_valid_tx, enc_type_tx}, 3'b100);
    check("tick_ignored", tick_pending_tx, 0);
    step();
    check("null_valid1", enc_valid_tx, 0);
    step();
    check("null_valid2", {enc_valid_tx, enc_type_tx}, 3'b100);
    check("null_others", {fifo_rd_tx, char_sent, fct_owed_tx, tick_pending_tx}, 0);

    // Three grants then three FCT transfers
    send_fct_tx = 1'b1; enc_ready_tx = 1'b0;
    fct_grant_tx = 1'b1;
    steps(3);
    fct_grant_tx = 1'b0;
    step();
    check("owed_three", fct_owed_tx, 3);
    for (int i = 0; i < 3; i++) expect_char(2'b01, 9'h000);
    enc_ready_tx = 1'b1;
    steps(10);
    check("owed_drained", fct_owed_tx, 0);
    check("fct_sb_empty", sb.size(), 0);

    // Saturation at 7, then link down clears it
    enc_ready_tx = 1'b0;
    fct_grant_tx = 1'b1;
    steps(9);
    fct_grant_tx = 1'b0;
    step();
    check("owed_sat", fct_owed_tx, 7);
    send_null_tx = 1'b0;
    step();
    check("down_owed", fct_owed_tx, 0);
    check("down_valid", enc_valid_tx, 0);

    // Two N-Chars with credit
    send_null_tx = 1'b1; send_nchar_tx = 1'b1; fct_credit_tx = 6'd8; enc_ready_tx = 1'b1;
    fq.push_back(9'h041); fq.push_back(9'h100); fifo_sync();
    expect_char(2'b10, 9'h041); expect_char(2'b10, 9'h100);
    pops0 = n_pops; sent0 = n_sent;
    steps(10);
    check("nchar_pops", n_pops - pops0, 2);
    check("nchar_sent", n_sent - sent0, 2);
    check("nchar_sb_empty", sb.size(), 0);
    check("credit_left", fct_credit_tx, 6);

    // No credit: NULLs only, nothing popped
    fct_credit_tx = 6'd0;
    fq.push_back(9'h041); fq.push_back(9'h100); fifo_sync();
    pops0 = n_pops; nulls0 = n_nulls;
    steps(8);
    check("nocredit_pops", n_pops - pops0, 0);
    check("nocredit_nulls", n_nulls > nulls0, 1);

    // Two ticks while an N-Char is held: latest value wins, sent before the next N-Char
    wait_idle();
    fct_credit_tx = 6'd8; enc_ready_tx = 1'b0;
    expect_char(2'b10, 9'h041);
    step();
    check("held_nchar", {enc_valid_tx, enc_type_tx}, 3'b110);
    tickin_tx = 1'b1; timein_tx = 8'h05;
    step();
    timein_tx = 8'h06;
    step();
    tickin_tx = 1'b0;
    check("tick_pending", tick_pending_tx, 1);
    expect_char(2'b11, 9'h006); expect_char(2'b10, 9'h100);
    enc_ready_tx = 1'b1;
    steps(10);
    check("tick_cleared", tick_pending_tx, 0);
    check("tick_sb_empty", sb.size(), 0);
    check("tick_fifo_empty", fq.size(), 0);

    // Link down while an N-Char is held: discarded, no char_sent
    wait_idle();
    fq.push_back(9'h0AA); fifo_sync();
    enc_ready_tx = 1'b0; fct_grant_tx = 1'b1;
    step();
    fct_grant_tx = 1'b0;
    check("drop_held", {enc_valid_tx, enc_type_tx, enc_data_tx}, {3'b110, 9'h0AA});
    check("drop_owed1", fct_owed_tx, 1);
    sent0 = n_sent;
    send_null_tx = 1'b0; enc_ready_tx = 1'b1;
    step();
    check("drop_valid", enc_valid_tx, 0);
    check("drop_owed0", fct_owed_tx, 0);
    step();
    check("drop_no_sent", n_sent - sent0, 0);
    check("drop_popped", fq.size(), 0);

    // Reset in the middle of a held character
    send_null_tx = 1'b1;
    step();
    wait_idle();
    enc_ready_tx = 1'b0; tickin_tx = 1'b1; timein_tx = 8'h33;
    step();
    tickin_tx = 1'b0;
    check("pre_rst_hold", {enc_valid_tx, tick_pending_tx}, 2'b11);
    rst_tx = 1'b1;
    step();
    check("rst_outs", {enc_valid_tx, enc_type_tx, enc_data_tx, fifo_rd_tx, char_sent,
                       fct_owed_tx, tick_pending_tx}, 0);
    rst_tx = 1'b0; enc_ready_tx = 1'b1;
    steps(6);
    check("post_rst_pending", tick_pending_tx, 0);
    check("post_rst_sb", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_char_scheduler.md
# tx_char_scheduler

Transmit-side character scheduler for the SpaceWire link. Each time the TX encoder can take a character, it picks one to send: time-code, FCT, N-Char or NULL. The choice follows the ECSS-E-ST-50-12C priority rules, the link-state permissions, the remote credit from the FCT credit counter, and the local count of FCTs owed to the far end. It sits between the TX data FIFO, the link FSM and the TX encoder, and returns `char_sent` to the FCT credit counter.

## Interface
- `OWED_W`, default 3: width of the owed-FCT counter; saturates at 2^OWED_W-1 (7 = 56 chars).
- `pclk_tx` in 1: TX clock; all logic is on its rising edge.
- `rst_tx` in 1: reset, synchronous, active-high.
- `send_null_tx` in 1: link FSM permits NULLs (Started or later); low means link down.
- `send_fct_tx` in 1: link FSM permits FCTs (Connecting or later).
- `send_nchar_tx` in 1: link FSM permits N-Chars and time-codes (Run).
- `tickin_tx` in 1: one-cycle time-code request.
- `timein_tx` in 8: time-code value, sampled when `tickin_tx`=1.
- `fct_grant_tx` in 1: one-cycle pulse from the RX buffer; 8 more slots are free, so one more FCT is owed.
- `fct_credit_tx` in 6: remote credit (N-Chars we may still send).
- `fifo_empty_tx` in 1: TX FIFO empty; the FIFO is first-word-fall-through.
- `fifo_data_tx` in 9: FIFO head; bit 8 = control flag (EOP/EEP).
- `enc_ready_tx` in 1: encoder accepts a character this cycle.
- `enc_valid_tx` out 1: character offered to the encoder.
- `enc_type_tx` out 2: 00 NULL, 01 FCT, 10 N-Char, 11 time-code.
- `enc_data_tx` out 9: N-Char data, or time-code in [7:0]; don't-care for NULL/FCT.
- `fifo_rd_tx` out 1: one-cycle FIFO pop.
- `char_sent` out 1: one-cycle pulse per N-Char accepted by the encoder.
- `fct_owed_tx` out OWED_W: current owed-FCT count.
- `tick_pending_tx` out 1: a time-code is waiting to be sent.

## Operation
- All outputs are registered. Reset value of every output is 0; state is IDLE; the latched time value is 0.
- State IDLE
  - Arbitrate every cycle. First match wins:
    1. `tick_pending_tx` and `send_nchar_tx`: time-code.
    2. `fct_owed_tx`≠0 and `send_fct_tx`: FCT.
    3. !`fifo_empty_tx` and `send_nchar_tx` and `fct_credit_tx`≠0: N-Char.
    4. `send_null_tx`: NULL.
    5. Otherwise stay in IDLE.
  - On a match: latch type and data into `enc_type_tx`/`enc_data_tx`, set `enc_valid_tx`, go to HOLD.
  - For an N-Char, also latch `fifo_data_tx` and assert `fifo_rd_tx` for exactly the first HOLD cycle.
- State HOLD
  - `enc_valid_tx`, type and data stay stable until a cycle with `enc_ready_tx`=1.
  - At that edge the character counts as transferred: drop `enc_valid_tx` and return to IDLE.
  - Later changes to `send_fct_tx`, `send_nchar_tx` or credit do not withdraw the held character.
- Effects of a transfer
  - FCT: `fct_owed_tx` decrements.
  - Time-code: `tick_pending_tx` clears.
  - N-Char: `char_sent`=1 for the next cycle.
- Owed counter
  - `fct_grant_tx` increments it, saturating at max.
  - Grant and FCT transfer in the same cycle leave it unchanged.
  - A grant while at max is dropped.
- Time-code latch
  - `tickin_tx` sets `tick_pending_tx` and latches `timein_tx`.
  - A new tick while one is pending overwrites the value (latest wins).
  - A tick in the same cycle as a time-code transfer leaves pending=1 with the new value.
  - A tick while `send_nchar_tx`=0 is ignored.
- Link down (`send_null_tx`=0), any state
  - Next cycle: IDLE, `enc_valid_tx`=0, `fct_owed_tx`=0, `tick_pending_tx`=0.
  - Grants and ticks are ignored.
  - A popped but untransferred N-Char is discarded, with no `char_sent`.
  - Takes precedence over a simultaneous `enc_ready_tx`.
- `rst_tx` has the same effect as link down, plus the time value is cleared. It overrides all other inputs.

## Timing
- Arbitration edge E0: `enc_valid_tx`=1 and `fifo_rd_tx`=1 (N-Char) from E0 to E1.
- `enc_ready_tx`=1 before E1: transfer at E1; `enc_valid_tx`=0 and `char_sent`=1 from E1 to E2.
- Next arbitration at E2. Maximum throughput is one character per 2 cycles; the FIFO flags have settled by E2.
- The credit decrement appears on `fct_credit_tx` one cycle after `char_sent`. Arbitration at E2 may see the old credit. Only one N-Char can issue in that window, and the counter never goes below 0.

## Test plan
- Reset, then `send_null_tx`=1, `enc_ready_tx`=1 -> NULLs (type 00) with `enc_valid_tx` high every other cycle; all other outputs 0.
- Three `fct_grant_tx` pulses, `send_fct_tx`=1 -> `fct_owed_tx`=3, then three type-01 transfers, then NULLs; 9 grants -> saturates at 7.
- Run with FIFO holding 0x041, 0x100 (EOP), credit 8 -> type-10 transfers with data 0x041, then 0x100; two `fifo_rd_tx` pulses and two `char_sent` pulses.
- Same FIFO contents with credit 0 -> NULLs only, no pop.
- Tick 0x05, then tick 0x06 while an N-Char is held with ready low -> after that N-Char transfers, one type-11 transfer with data 0x06; pending then 0.
- N-Char held with ready low, then `send_null_tx` drops -> `enc_valid_tx`=0 next cycle, owed=0, no `char_sent`.
- `rst_tx` asserted mid-HOLD -> all outputs 0 next cycle.
